// File: rtl/nx_arbiter_pkg.sv
// Shared types and helpers for the Nexus message arbiter.
package nx_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int STAT_CNT_W = 16;

    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nx_rr_picker.sv
// Combinational rotating-priority picker: first valid index at or after start_i, wrapping.
module nx_rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] start_i,
    output logic          has_grant_o,
    output logic [IW-1:0] grant_o
);

    int best_dist_s;
    int dist_s;

    // Smallest forward distance from start_i among valid requesters wins.
    always_comb begin
        best_dist_s = N;
        dist_s      = 0;
        grant_o     = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            dist_s = (i - int'(start_i) + N) % N;
            if (valid_i[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                grant_o     = IW'(i);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
        has_grant_o = (best_dist_s < N);
    end

endmodule

// File: rtl/nx_msg_arbiter.sv
// Round-robin burst-locking arbiter onto one registered Nexus message stream.
// Optional per-requester grant counters when NX_ARB_STATS_EN is defined.
module nx_msg_arbiter
    import nx_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 2,
    parameter int DATA_WIDTH = 31,
    parameter int MAX_BURST  = 8,
    parameter int SRC_WIDTH  = src_width(REQUESTERS)
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] req_data_i,
    input  logic [REQUESTERS-1:0]            req_valid_i,
    output logic [REQUESTERS-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]            arb_data_o,
    output logic [SRC_WIDTH-1:0]             arb_src_o,
    output logic                             arb_valid_o,
    input  logic                             arb_ready_i
`ifdef NX_ARB_STATS_EN
    ,
    input  logic                             stat_clear_i,
    output logic [REQUESTERS*STAT_CNT_W-1:0] stat_grants_o
`endif
);

    localparam int SW = SRC_WIDTH;
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t      state_q, state_d;
    logic [SW-1:0]   owner_q, owner_d;
    logic [SW-1:0]   last_grant_q, last_grant_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [SW-1:0]   src_q;
    logic            valid_q;

    logic            load_en_s;
    logic            lock_keep_s;
    logic [SW-1:0]   base_s, start_s;
    logic            pick_has_s;
    logic [SW-1:0]   pick_grant_s;
    logic            has_grant_s;
    logic [SW-1:0]   grant_s;
    logic [REQUESTERS-1:0] req_ready_s;
    logic            xfer_s;

    assign load_en_s   = ~valid_q | arb_ready_i;
    assign lock_keep_s = (state_q == ARB_LOCKED) && req_valid_i[owner_q] &&
                         (burst_cnt_q < BW'(MAX_BURST));

    // In LOCKED the owner is always the last grant, so both scan from the successor.
    assign base_s  = (state_q == ARB_LOCKED) ? owner_q : last_grant_q;
    assign start_s = (base_s == SW'(REQUESTERS - 1)) ? {SW{1'b0}} : base_s + SW'(1);

    nx_rr_picker #(
        .N  (REQUESTERS),
        .IW (SW)
    ) u_picker (
        .valid_i     (req_valid_i),
        .start_i     (start_s),
        .has_grant_o (pick_has_s),
        .grant_o     (pick_grant_s)
    );

    assign has_grant_s = lock_keep_s | pick_has_s;
    assign grant_s     = lock_keep_s ? owner_q : pick_grant_s;

    // One-hot ready to the winner; forced low while in reset.
    always_comb begin
        req_ready_s = {REQUESTERS{1'b0}};
        if (rstn_i && load_en_s && has_grant_s) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = {REQUESTERS{1'b0}};
        end
    end

    assign req_ready_o = req_ready_s;
    assign xfer_s      = |(req_ready_s & req_valid_i);

    // Arbitration next state; everything frozen under backpressure.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        if (xfer_s) begin
            state_d      = ARB_LOCKED;
            owner_d      = grant_s;
            last_grant_d = grant_s;
            burst_cnt_d  = lock_keep_s ? (burst_cnt_q + BW'(1)) : BW'(1);
        end else if (load_en_s) begin
            state_d     = ARB_IDLE;
            burst_cnt_d = {BW{1'b0}};
        end else begin
            state_d = state_q;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ARB_IDLE;
            owner_q      <= {SW{1'b0}};
            last_grant_q <= SW'(REQUESTERS - 1);
            burst_cnt_q  <= {BW{1'b0}};
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Output register: load on transfer, drain when empty-accepting, else hold.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_q  <= {DATA_WIDTH{1'b0}};
            src_q   <= {SW{1'b0}};
            valid_q <= 1'b0;
        end else if (xfer_s) begin
            data_q  <= req_data_i[int'(grant_s)*DATA_WIDTH +: DATA_WIDTH];
            src_q   <= grant_s;
            valid_q <= 1'b1;
        end else if (load_en_s) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign arb_data_o  = data_q;
    assign arb_src_o   = src_q;
    assign arb_valid_o = valid_q;

`ifdef NX_ARB_STATS_EN
    logic [STAT_CNT_W-1:0] grant_cnt_q [REQUESTERS];

    for (genvar g = 0; g < REQUESTERS; g++) begin : g_stats
        // Saturating grant counter; clear has priority over a same-cycle grant.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                grant_cnt_q[g] <= {STAT_CNT_W{1'b0}};
            end else if (stat_clear_i) begin
                grant_cnt_q[g] <= {STAT_CNT_W{1'b0}};
            end else if (xfer_s && (grant_s == SW'(g)) &&
                         (grant_cnt_q[g] != {STAT_CNT_W{1'b1}})) begin
                grant_cnt_q[g] <= grant_cnt_q[g] + STAT_CNT_W'(1);
            end else begin
                grant_cnt_q[g] <= grant_cnt_q[g];
            end
        end
        assign stat_grants_o[g*STAT_CNT_W +: STAT_CNT_W] = grant_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_nx_msg_arbiter.sv
// Directed table-driven bench for nx_msg_arbiter (MAX_BURST=8 and MAX_BURST=1 instances).
module tb_nx_msg_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [61:0] req_data;
    logic [1:0]  req_valid;
    logic        arb_ready;

    logic [1:0]  rr0, rr1;
    logic [30:0] data0, data1;
    logic        src0, src1;
    logic        vld0, vld1;
`ifdef NX_ARB_STATS_EN
    logic        stat_clear;
    logic [31:0] stats0, stats1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nx_msg_arbiter #(.REQUESTERS(2), .DATA_WIDTH(31), .MAX_BURST(8)) u0 (
        .clk_i(clk), .rstn_i(rstn), .req_data_i(req_data), .req_valid_i(req_valid),
        .req_ready_o(rr0), .arb_data_o(data0), .arb_src_o(src0), .arb_valid_o(vld0),
        .arb_ready_i(arb_ready)
`ifdef NX_ARB_STATS_EN
        , .stat_clear_i(stat_clear), .stat_grants_o(stats0)
`endif
    );

    nx_msg_arbiter #(.REQUESTERS(2), .DATA_WIDTH(31), .MAX_BURST(1)) u1 (
        .clk_i(clk), .rstn_i(rstn), .req_data_i(req_data), .req_valid_i(req_valid),
        .req_ready_o(rr1), .arb_data_o(data1), .arb_src_o(src1), .arb_valid_o(vld1),
        .arb_ready_i(arb_ready)
`ifdef NX_ARB_STATS_EN
        , .stat_clear_i(stat_clear), .stat_grants_o(stats1)
`endif
    );

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic        rdy;
        logic [30:0] d0;
        logic [30:0] d1;
        logic [1:0]  rr;
        logic        ov;
        logic        os;
        logic [30:0] od;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rstn      = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 2'b11;
        req_data  = 62'h0;
        arb_ready = 1'b1;
`ifdef NX_ARB_STATS_EN
        stat_clear = 1'b0;
`endif
        #2;
        chk("reset_valid", 64'(vld0), 64'h0);
        chk("reset_data", 64'(data0), 64'h0);
        chk("reset_src", 64'(src0), 64'h0);
        chk("reset_ready", 64'(rr0), 64'h0);
        reset_dut();

        //         rst   v      rdy   d0          d1         rr     ov    os    od
        tbl[0]  = '{1'b1, 2'b01, 1'b1, 31'h1,     31'h0,     2'b01, 1'b1, 1'b0, 31'h1};
        tbl[1]  = '{1'b0, 2'b01, 1'b1, 31'h2,     31'h0,     2'b01, 1'b1, 1'b0, 31'h2};
        tbl[2]  = '{1'b0, 2'b01, 1'b1, 31'h3,     31'h0,     2'b01, 1'b1, 1'b0, 31'h3};
        tbl[3]  = '{1'b0, 2'b00, 1'b1, 31'h0,     31'h0,     2'b00, 1'b0, 1'b0, 31'h0};
        tbl[4]  = '{1'b0, 2'b01, 1'b1, 31'h5A5A,  31'h0,     2'b01, 1'b1, 1'b0, 31'h5A5A};
        for (int i = 5; i < 10; i++)
            tbl[i] = '{1'b0, 2'b01, 1'b0, 31'h1111, 31'h0,   2'b00, 1'b1, 1'b0, 31'h5A5A};
        tbl[10] = '{1'b0, 2'b01, 1'b1, 31'h1111,  31'h0,     2'b01, 1'b1, 1'b0, 31'h1111};
        tbl[11] = '{1'b0, 2'b00, 1'b1, 31'h0,     31'h0,     2'b00, 1'b0, 1'b0, 31'h0};
        tbl[12] = '{1'b1, 2'b11, 1'b1, 31'hA1,    31'hB1,    2'b01, 1'b1, 1'b0, 31'hA1};
        tbl[13] = '{1'b0, 2'b11, 1'b1, 31'hA2,    31'hB1,    2'b01, 1'b1, 1'b0, 31'hA2};
        tbl[14] = '{1'b0, 2'b11, 1'b1, 31'hA3,    31'hB1,    2'b01, 1'b1, 1'b0, 31'hA3};
        tbl[15] = '{1'b0, 2'b10, 1'b1, 31'h0,     31'hB1,    2'b10, 1'b1, 1'b1, 31'hB1};
        tbl[16] = '{1'b0, 2'b11, 1'b1, 31'hA4,    31'hB2,    2'b10, 1'b1, 1'b1, 31'hB2};
        tbl[17] = '{1'b0, 2'b00, 1'b1, 31'h0,     31'h0,     2'b00, 1'b0, 1'b0, 31'h0};

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rst) reset_dut();
            @(negedge clk);
            req_valid = tbl[i].v;
            arb_ready = tbl[i].rdy;
            req_data  = {tbl[i].d1, tbl[i].d0};
            #1;
            chk($sformatf("vec%0d_req_ready", i), 64'(rr0), 64'(tbl[i].rr));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 64'(vld0), 64'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk($sformatf("vec%0d_src", i), 64'(src0), 64'(tbl[i].os));
                chk($sformatf("vec%0d_data", i), 64'(data0), 64'(tbl[i].od));
            end
        end

        // Both requesters always valid: runs of 8 on u0, strict alternation on u1.
        reset_dut();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            req_valid = 2'b11;
            arb_ready = 1'b1;
            req_data  = {31'(32'h100 + i), 31'(i)};
            @(posedge clk);
            #1;
            chk($sformatf("burst%0d_valid", i), 64'(vld0), 64'h1);
            chk($sformatf("burst%0d_src", i), 64'(src0), 64'(((i / 8) % 2)));
            chk($sformatf("burst%0d_data", i), 64'(data0),
                (((i / 8) % 2) == 1) ? 64'(32'h100 + i) : 64'(i));
            chk($sformatf("rr1_%0d_src", i), 64'(src1), 64'((i % 2)));
        end

        // Mid-operation reset drops an in-flight message from requester 1.
        reset_dut();
        @(negedge clk);
        req_valid = 2'b10;
        req_data  = {31'h77, 31'h0};
        arb_ready = 1'b1;
        @(negedge clk);
        arb_ready = 1'b0;
        chk("inflight_valid", 64'(vld0), 64'h1);
        chk("inflight_src", 64'(src0), 64'h1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("async_rst_valid", 64'(vld0), 64'h0);
        chk("async_rst_data", 64'(data0), 64'h0);
        chk("async_rst_ready", 64'(rr0), 64'h0);
        @(negedge clk);
        rstn      = 1'b1;
        req_valid = 2'b11;
        req_data  = {31'h22, 31'h11};
        arb_ready = 1'b1;
        #1;
        chk("post_rst_ready", 64'(rr0), 64'h1);
        @(posedge clk);
        #1;
        chk("post_rst_src", 64'(src0), 64'h0);
        chk("post_rst_data", 64'(data0), 64'h11);

`ifdef NX_ARB_STATS_EN
        reset_dut();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req_valid = 2'b10;
            req_data  = {31'(i), 31'h0};
            arb_ready = 1'b1;
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("stat_req1", 64'(stats0[31:16]), 64'd20);
        chk("stat_req0", 64'(stats0[15:0]), 64'd0);
        req_valid  = 2'b01;
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
        req_valid  = 2'b00;
        #1;
        chk("stat_clear_req1", 64'(stats0[31:16]), 64'd0);
        chk("stat_clear_wins", 64'(stats0[15:0]), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nx_msg_arbiter.md
Name: nx_msg_arbiter

Overview:
Round-robin arbiter sharing one Nexus 31-bit message stream (valid/ready) between REQUESTERS sources. Example use: merging the core's control and mesh outbound streams onto a single AXI4-stream bridge.
Burst-locking with a fairness cap, plus a registered output stage with source tag so the consumer can route or demultiplex.
Sits between message producers (nexus core, bridges) and a single downstream consumer.

Parameters:
REQUESTERS, 2, number of input message streams (>=2)
DATA_WIDTH, 31, Nexus message width in bits
MAX_BURST, 8, max consecutive grants to one requester before re-arbitration (>=1)

Ports:
clk_i  input  1  clock
rstn_i  input  1  asynchronous active-low reset
req_data_i  input  REQUESTERS*DATA_WIDTH  packed messages; requester n at [n*DATA_WIDTH +: DATA_WIDTH]
req_valid_i  input  REQUESTERS  per-requester valid
req_ready_o  output  REQUESTERS  per-requester ready (one-hot or zero)
arb_data_o  output  DATA_WIDTH  registered winning message
arb_src_o  output  SRC_WIDTH  index of requester that sourced arb_data_o; SRC_WIDTH = max(1, $clog2(REQUESTERS))
arb_valid_o  output  1  output valid
arb_ready_i  input  1  downstream ready

Behaviour:
- Reset values: arb_valid_o=0, arb_data_o=0, arb_src_o=0, last_grant=REQUESTERS-1 (so requester 0 wins first), burst_cnt=0, state=IDLE. req_ready_o=0 while rstn_i low.
- load_en = ~arb_valid_o | arb_ready_i. Output register accepts a new message when load_en=1.
- req_ready_o[g] = load_en & has_grant & (g==grant). This is a combinational path from arb_ready_i and req_valid_i; no skid buffer.
- A transfer is req_valid_i[g] & req_ready_o[g]. On transfer: arb_data_o<=req data, arb_src_o<=g, arb_valid_o<=1.
- If load_en and no transfer, arb_valid_o<=0. Otherwise the output holds its value.
- Latency is 1 cycle from input transfer to arb_valid_o. Throughput is 1 message/cycle when arb_ready_i is held high; drain and load in the same cycle are legal.
- arb_data_o and arb_src_o stay stable while arb_valid_o=1 & arb_ready_i=0.
- States:
  - IDLE: no owner. Grant = first valid requester scanning from last_grant+1 modulo REQUESTERS. A transfer moves to LOCKED with owner=g, burst_cnt=1.
  - LOCKED: if req_valid_i[owner] and burst_cnt<MAX_BURST, grant=owner; each transfer increments burst_cnt.
  - Leaving LOCKED: if owner drops valid, or burst_cnt==MAX_BURST, re-arbitrate as in IDLE from owner+1. A transfer by a new winner gives owner=new, burst_cnt=1. No transfer returns to IDLE.
  - The cap-expired owner may win again only if no other requester is valid; burst_cnt then resets to 1.
- last_grant updates on every transfer.
- burst_cnt width is $clog2(MAX_BURST+1). It never exceeds MAX_BURST.
- MAX_BURST=1 gives pure per-message round-robin.
- Backpressure (load_en=0): state, last_grant and burst_cnt are frozen and no ready is asserted.
- Mid-operation reset: clears the output register (an in-flight message is dropped) and all arbitration state.

Optional Feature:
Macro NX_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants_o (REQUESTERS*16 bits) and input stat_clear_i (1 bit).
  - Per-requester 16-bit grant counters increment on each transfer, saturate at 0xFFFF, reset to 0, and synchronously clear on stat_clear_i.
  - If clear and transfer occur in the same cycle, clear wins.
- Undefined: the ports and counters are absent; arbitration behaviour is identical.

Decomposition:
- Package nx_arbiter_pkg: arb_state_t enum {ARB_IDLE, ARB_LOCKED}, SRC_WIDTH helper function, stats counter width constant (16).
- One sub-module, nx_rr_picker: a combinational rotating-priority picker. Inputs are the valid vector and start index; outputs are has_grant and grant index. The arbiter instantiates it once.

Test Plan:
- Reset, then requester 0 only, 3 messages 0x1,0x2,0x3, arb_ready_i=1 -> outputs appear on consecutive cycles with 1-cycle latency, arb_src_o=0 each time; arb_valid_o=0 after reset.
- Both valid continuously, MAX_BURST=8, ready=1 -> source sequence 0x8 then 1x8 then 0x8 (each run of 8); no cycle without output.
- Both valid, MAX_BURST=1 -> sources alternate 0,1,0,1.
- Output stalled (arb_ready_i=0) for 5 cycles with message 0x5A5A pending -> arb_data_o holds 0x5A5A, req_ready_o=0; on release the next message follows on the next cycle.
- Owner drops valid mid-burst at burst_cnt=3 -> requester 1 granted next cycle, its burst_cnt=1.
- rstn_i pulsed low while arb_valid_o=1 -> arb_valid_o=0 immediately (async); after release requester 0 has priority again. With NX_ARB_STATS_EN, 20 grants to requester 1 read back as 20; stat_clear_i sets the counter to 0.
